// File: rtl/comp_gain_loader.sv
// Streams a 64x8 shadow gain table (or unity gains) into the compressor's serial
// gain ROM as one unbroken 64-beat burst, highest entry index first.
module comp_gain_loader #(
  parameter logic [7:0] UNITY     = 8'h10,
  parameter bit         AUTO_INIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] hwa,
  input  logic [7:0] hwd,
  input  logic       hwe,
  input  logic       load,
  input  logic       bypass,
  output logic [7:0] cin,
  output logic       cwe,
  output logic       busy,
  output logic       done,
  output logic       werr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       src_byp_q, src_byp_d;
  logic       pend_q;
  logic       last_q;
  logic [7:0] cin_q, cin_d;
  logic       cwe_q, cwe_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       werr_q, werr_d;
  logic       start_s;
  logic       wr_en_s;
  logic [7:0] mem_q [64];

  assign start_s = load | bypass | pend_q;
  assign wr_en_s = hwe & (state_q == IDLE) & ~rst;

  // Shadow table write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[hwa] <= hwd;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd63;
      src_byp_q <= 1'b0;
      pend_q    <= AUTO_INIT;
      last_q    <= 1'b0;
      cin_q     <= 8'h00;
      cwe_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src_byp_q <= src_byp_d;
      pend_q    <= 1'b0;
      last_q    <= (state_q == SHIFT) && (cnt_q == 6'd0);
      cin_q     <= cin_d;
      cwe_q     <= cwe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      werr_q    <= werr_d;
    end
  end

  // Next-state: last_q marks the cycle whose data is entry 0
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_byp_d = src_byp_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d   = PRIME;
          cnt_d     = 6'd63;
          src_byp_d = bypass | pend_q;
        end else begin
          state_d = IDLE;
        end
      end
      PRIME: begin
        state_d = SHIFT;
        cnt_d   = cnt_q - 6'd1;
      end
      SHIFT: begin
        if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end else begin
          cnt_d = cnt_q;
        end
        if (last_q) begin
          state_d = FIN;
        end else begin
          state_d = SHIFT;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so they register in step with it;
  // the table read at cnt_q lands in cin one cycle later (read runs ahead)
  always_comb begin
    busy_d = (state_d == PRIME) || (state_d == SHIFT);
    cwe_d  = (state_d == SHIFT);
    done_d = (state_d == FIN);
    werr_d = hwe && (state_q != IDLE);
    cin_d  = 8'h00;
    if (cwe_d) begin
      if (src_byp_q) begin
        cin_d = UNITY;
      end else begin
        cin_d = mem_q[cnt_q];
      end
    end else begin
      cin_d = 8'h00;
    end
  end

  assign cin  = cin_q;
  assign cwe  = cwe_q;
  assign busy = busy_q;
  assign done = done_q;
  assign werr = werr_q;

endmodule

// File: tb/tb_comp_gain_loader.sv
// Randomized bench for comp_gain_loader: burst timing, beat order and the
// resulting compressor ROM image are checked against a table-level model.
module tb_comp_gain_loader;

  localparam logic [7:0] UNITY = 8'h10;

  logic       clk;
  logic       rst;
  logic [5:0] hwa;
  logic [7:0] hwd;
  logic       hwe;
  logic       load;
  logic       bypass;
  logic [7:0] cin;
  logic       cwe;
  logic       busy;
  logic       done;
  logic       werr;

  int         n_chk;
  int         n_fail;
  logic [7:0] ref_tab [64];
  logic [7:0] rom [64];
  logic [5:0] inj_a;
  logic [7:0] inj_d;

  comp_gain_loader #(.UNITY(UNITY), .AUTO_INIT(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .hwa    (hwa),
    .hwd    (hwd),
    .hwe    (hwe),
    .load   (load),
    .bypass (bypass),
    .cin    (cin),
    .cwe    (cwe),
    .busy   (busy),
    .done   (done),
    .werr   (werr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compressor ROM model: each beat shifts in, so the first beat ends at address 63
  always @(negedge clk) begin
    if (cwe === 1'b1) begin
      for (int i = 63; i > 0; i--) rom[i] <= rom[i-1];
      rom[0] <= cin;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    hwe = 1'b1; hwa = a; hwd = d;
    ref_tab[a] = d;
    @(negedge clk);
    hwe = 1'b0;
  endtask

  task automatic check_rom(input bit byp, input string tag);
    for (int i = 0; i < 64; i++) check_eq(tag, rom[i], byp ? UNITY : ref_tab[i]);
  endtask

  // Issue a command at the current negedge (cycle 0) and check cycles 1..68.
  // inj>0 pokes a write+command in cycle inj; abort_at>0 asserts rst in that cycle.
  task automatic burst(input bit ld, input bit bp, input bit auto_src, input bit wr_en,
                       input logic [5:0] wa, input logic [7:0] wd,
                       input int inj, input int abort_at);
    logic [7:0] ent [64];
    int beats;
    bit byp;
    load = ld; bypass = bp;
    if (wr_en) begin
      hwe = 1'b1; hwa = wa; hwd = wd;
      ref_tab[wa] = wd;
    end
    byp = bp | auto_src;
    for (int i = 0; i < 64; i++) ent[i] = byp ? UNITY : ref_tab[i];
    beats = 0;
    @(posedge clk);
    for (int j = 1; j <= 68; j++) begin
      @(negedge clk);
      if (j == 1 || j == inj + 1) begin
        load = 1'b0; bypass = 1'b0; hwe = 1'b0;
      end
      check_eq("busy", busy, (j >= 1 && j <= 65));
      check_eq("cwe", cwe, (j >= 2 && j <= 65));
      check_eq("cin", cin, (j >= 2 && j <= 65) ? ent[65-j] : 8'h00);
      check_eq("done", done, (j == 66));
      check_eq("werr", werr, (inj > 0 && j == inj + 1));
      if (cwe === 1'b1) beats++;
      if (j == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_cwe", cwe, 1'b0);
        check_eq("abort_cin", cin, 8'h00);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_busy", busy, 1'b0);
        return;
      end
      if (j == inj) begin
        hwe = 1'b1; hwa = inj_a; hwd = inj_d;
        load = 1'b1; bypass = 1'($urandom_range(0, 1));
      end
    end
    check_eq("beats", beats, 64);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; hwe = 1'b0; load = 1'b0; bypass = 1'b0;
    hwa = 6'd0; hwd = 8'h00; inj_a = 6'd0; inj_d = 8'h00;
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("rst_cin", cin, 8'h00);
      check_eq("rst_cwe", cwe, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_werr", werr, 1'b0);
    end
    rst = 1'b0;
    burst(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 8'h00, 0, 0);
    check_rom(1'b1, "rom_auto");

    for (int i = 0; i < 64; i++) wr(6'(i), 8'(i + 1));
    burst(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 0, 0);
    check_rom(1'b0, "rom_ramp");

    burst(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 8'h00, 0, 0);
    check_rom(1'b1, "rom_both");
    burst(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 0, 0);
    check_rom(1'b0, "rom_after_both");

    inj_a = 6'd5; inj_d = 8'hAA;
    burst(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 10, 0);
    burst(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 0, 0);
    check_eq("tab5_kept", rom[5], 8'h06);

    burst(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 0, 21);
    rst = 1'b0;
    burst(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 8'h00, 0, 0);
    check_rom(1'b1, "rom_after_abort");

    burst(1'b1, 1'b0, 1'b0, 1'b1, 6'd63, 8'h7F, 0, 0);
    check_eq("first_beat_7f", rom[63], 8'h7F);

    for (int r = 0; r < 6; r++) begin
      int nw;
      int kind;
      int inj;
      nw = $urandom_range(1, 20);
      for (int w = 0; w < nw; w++) begin
        wr(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      kind  = $urandom_range(0, 2);
      inj   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 65);
      inj_a = 6'($urandom_range(0, 63));
      inj_d = 8'($urandom_range(0, 255));
      burst(kind != 1, kind != 0, 1'b0, 1'($urandom_range(0, 1)),
            6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)), inj, 0);
      check_rom(kind != 0, "rom_rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/comp_gain_loader.md
Name: comp_gain_loader

Overview:
- Configuration controller for the compressor's 64-entry serial gain ROM. The ROM is loaded through an 8-bit configuration byte plus write enable, one entry per enabled clock, largest-magnitude entry first.
- The host writes entries at random into a local 64x8 shadow table. A load command then streams the whole table into the compressor in one uninterrupted 64-cycle burst, in the correct order.
- A bypass command streams 64 unity-gain entries without touching the shadow table.
- After reset the block auto-loads the compressor to a defined state.

Parameters:
- UNITY, 8'h10, unity-gain entry (4.4 format) used by bypass and the auto-init load.
- AUTO_INIT, 1, when 1 a bypass burst starts automatically on the first cycle after reset deasserts.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- hwa  in  6  host write address; entry index = magnitude index 0..63
- hwd  in  8  host write data (gain entry)
- hwe  in  1  host write enable
- load  in  1  start burst from the shadow table (single-cycle pulse)
- bypass  in  1  start burst of UNITY entries (single-cycle pulse)
- cin  out  8  configuration byte to the compressor
- cwe  out  1  configuration shift enable to the compressor
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when a burst completes
- werr  out  1  one-cycle pulse when a host write is dropped

Behaviour:
- Reset values:
  - cin=0, cwe=0, busy=0, done=0, werr=0, FSM=IDLE, address counter=63.
  - The shadow table is not cleared by reset.
  - If AUTO_INIT=1, the FSM leaves reset with a pending bypass request. The request is taken on the first cycle after rst deasserts, exactly as if bypass were pulsed in that cycle.
- Shadow table:
  - Synchronous-write, synchronous-read, 64x8.
  - A write with hwe=1 in IDLE stores hwd at hwa at the clock edge.
- FSM states: IDLE, PRIME, SHIFT, FIN.
  - IDLE: load or bypass sampled high -> PRIME. Latch the source select (table or UNITY); bypass wins if both are high. Set counter=63.
  - PRIME (1 cycle): busy=1. Shadow read of address 63 issued. -> SHIFT.
  - SHIFT (64 cycles):
    - cwe=1. cin = table[counter] (registered read data) or UNITY.
    - The counter decrements each cycle; the read address runs one ahead of the data.
    - Entry order on cin: 63, 62, ..., 0. The last cwe cycle carries entry 0.
    - -> FIN after the cycle carrying entry 0.
  - FIN (1 cycle): done=1, busy=0, cwe=0. -> IDLE.
- Timing: command sampled in cycle 0.
  - busy high in cycles 1..65.
  - cwe high in cycles 2..65.
  - done high in cycle 66.
  - A new command is accepted in cycle 67 at the earliest (IDLE).
  - Total: 64 cwe pulses, never gapped, never more or fewer.
- cin is 0 whenever cwe=0.
- Commands (load/bypass) arriving while not in IDLE are ignored; they are not queued.
- Host writes:
  - hwe=1 while not in IDLE: the write is dropped and werr pulses the following cycle.
  - hwe=1 together with load in IDLE: the write is performed and the load then reads the updated table.
- rst during a burst:
  - Aborts immediately: cwe=0 next cycle, no done pulse.
  - The compressor ROM is left partially shifted. With AUTO_INIT=1 the subsequent auto bypass restores a defined state.
- No arithmetic on entries; data passes through unmodified.

Test Plan:
- Reset with AUTO_INIT=1, no stimulus -> busy high in cycles 1..65 after reset release; exactly 64 cwe cycles with cin=8'h10; done pulse in cycle 66; cin=0 after.
- Write table[i]=i+1 for i=0..63, pulse load -> cwe beats carry 64,63,...,1 in that order; the compressor model's ROM then holds entry i at address i for all i.
- Pulse load and bypass in the same cycle -> 64 beats of 8'h10; the shadow table is unchanged; a following load streams the previously written values.
- During a burst: pulse hwe with hwa=5, hwd=8'hAA and pulse load -> werr pulses once; table[5] unchanged; the burst completes with exactly 64 beats; no second burst starts.
- Assert rst at beat 20 of a load burst -> cwe=0 the next cycle, no done; after release a bypass burst of 64 beats with 8'h10 runs.
- hwe with hwa=63, hwd=8'h7F and load in the same IDLE cycle -> the first beat carries 8'h7F.
